button_event_bank: RTL and testbench

Parametrised input-conditioning bank between the raw IO-shield push buttons and the game loop. It synchronises and debounces each of CHANNELS buttons. Per channel it produces a stable level plus single-cycle press and release pulses, with optional hold-to-repeat on selected channels. A priority-encoded event code lets the game loop take one move per cycle instead of sampling raw bouncing inputs.

---
 rtl/button_event_bank.sv | 145 ++++++++++++++
 tb/tb_button_event_bank.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/button_event_bank.sv
// button_event_bank: synchronises and debounces a bank of raw push buttons.
// Each channel yields a stable level, single-cycle press/release pulses and
// optional hold-to-repeat press pulses. A priority encoder reports the
// lowest-numbered pressing channel so the game loop can take one move per cycle.
module button_event_bank #(
   parameter int                    CHANNELS        = 6,
   parameter int                    DEBOUNCE_CYCLES = 500000,
   parameter int                    REPEAT_DELAY    = 25000000,
   parameter int                    REPEAT_RATE     = 5000000,
   parameter logic [CHANNELS-1:0]   REPEAT_MASK     = {CHANNELS{1'b0}},
   localparam int                   CODE_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   // Named release_o because "release" is a reserved SystemVerilog keyword.
   output logic [CHANNELS-1:0] release_o,
   output logic                event_valid,
   output logic [CODE_W-1:0]   event_code
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
   localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

   // Two-flop synchroniser stages.
   logic [CHANNELS-1:0] sync1_q;
   logic [CHANNELS-1:0] sync2_q;

   // Debounced level and registered edge pulses.
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] press_q, press_d;
   logic [CHANNELS-1:0] release_q, release_d;

   // Per-channel debounce and hold-to-repeat state. rate_phase is set once the
   // first (longer) repeat delay has elapsed.
   logic [DB_W-1:0]     db_cnt_q   [CHANNELS];
   logic [DB_W-1:0]     db_cnt_d   [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt_q [CHANNELS];
   logic [HOLD_W-1:0]   hold_cnt_d [CHANNELS];
   logic [CHANNELS-1:0] rate_phase_q, rate_phase_d;

   // Bring the asynchronous button levels into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   // Next-state for debounce, edge detection and hold-to-repeat per channel.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves a signal unassigned and infers a latch.
      level_d      = level_q;
      press_d      = '0;
      release_d    = '0;
      rate_phase_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         db_cnt_d[i]   = '0;
         hold_cnt_d[i] = '0;

         // Count consecutive mismatching cycles; any matching cycle restarts.
         if (sync2_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               level_d[i] = ~level_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
            end
         end

         // Hold timing only runs while the level stays high across the edge:
         // the press edge and the release edge both leave it cleared, which
         // also keeps a repeat from ever landing on a release cycle.
         if (REPEAT_MASK[i] && level_q[i] && level_d[i]) begin
            if (hold_cnt_q[i] == (rate_phase_q[i] ? RATE_LAST : DELAY_LAST)) begin
               press_d[i]      = 1'b1;
               rate_phase_d[i] = 1'b1;
            end else begin
               hold_cnt_d[i]   = hold_cnt_q[i] + HOLD_ONE;
               rate_phase_d[i] = rate_phase_q[i];
            end
         end

         if (level_d[i] && !level_q[i]) begin
            press_d[i] = 1'b1;
         end
         if (!level_d[i] && level_q[i]) begin
            release_d[i] = 1'b1;
         end
      end
   end

   // Register debounced state, pulses and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q      <= '0;
         press_q      <= '0;
         release_q    <= '0;
         rate_phase_q <= '0;
         // NOTE: the counter arrays are ordinary flops, not RAM, and must be
         // reset so a mid-debounce or mid-hold reset aborts pending changes.
         for (int i = 0; i < CHANNELS; i++) begin
            db_cnt_q[i]   <= '0;
            hold_cnt_q[i] <= '0;
         end
      end else begin
         level_q      <= level_d;
         press_q      <= press_d;
         release_q    <= release_d;
         rate_phase_q <= rate_phase_d;
         db_cnt_q     <= db_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   // Priority encoder: lowest-numbered asserted press bit wins.
   always_comb begin
      event_code = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (press_q[i]) begin
            event_code = i[CODE_W-1:0];
         end
      end
   end

   assign event_valid = |press_q;
   assign level       = level_q;
   assign press       = press_q;
   assign release_o   = release_q;

endmodule

// File: tb/tb_button_event_bank.sv
// Directed testbench for button_event_bank using short debounce/repeat
// parameters. Inputs change on the falling edge, outputs are sampled on the
// falling edge after each rising edge; edge e counts rising edges from the
// point the stimulus was applied.
module tb_button_event_bank;

   localparam int CH = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CH-1:0] btn_in = '0;
   logic [CH-1:0] level;
   logic [CH-1:0] press;
   logic [CH-1:0] release_o;
   logic          event_valid;
   logic [2:0]    event_code;

   int            checks = 0;
   int            errors = 0;
   logic [CH-1:0] exp_lvl = '0;
   logic [7:0]    bounce_pat = 8'b0111_0111;  // bit e-1 drives edge e: 1,1,1,0,1,1,1,0
   int            pulse_cnt;

   always #5 clk = ~clk;

   button_event_bank #(
      .CHANNELS        (CH),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3),
      .REPEAT_MASK     (6'b011101)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_in      (btn_in),
      .level       (level),
      .press       (press),
      .release_o   (release_o),
      .event_valid (event_valid),
      .event_code  (event_code)
   );

   // Single comparison point: counts and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] lowest(input logic [CH-1:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (v[i]) r = i[2:0];
      end
      return r;
   endfunction

   // Compare every output against the expected pulses and tracked level.
   task automatic check_out(input string tag, input logic [CH-1:0] ep, input logic [CH-1:0] er);
      check({tag, ".level"},       32'(level),       32'(exp_lvl));
      check({tag, ".press"},       32'(press),       32'(ep));
      check({tag, ".release"},     32'(release_o),   32'(er));
      check({tag, ".event_valid"}, 32'(event_valid), 32'(|ep));
      check({tag, ".event_code"},  32'(event_code),  32'(lowest(ep)));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [CH-1:0] ep;
      logic [CH-1:0] er;

      // ---- reset state ----
      idle(2);
      check_out("reset", '0, '0);
      rst_n = 1'b1;
      idle(3);

      // ---- clean press and release on channel 1 (repeat disabled) ----
      btn_in[1] = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         @(negedge clk);
         if (e == 6) exp_lvl[1] = 1'b1;
         ep = (e == 6) ? 6'b000010 : 6'b000000;
         check_out($sformatf("clean_press e%0d", e), ep, '0);
      end
      btn_in[1] = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         @(negedge clk);
         if (e == 6) exp_lvl[1] = 1'b0;
         er = (e == 6) ? 6'b000010 : 6'b000000;
         check_out($sformatf("clean_release e%0d", e), '0, er);
      end
      idle(4);

      // ---- bounce on channel 3, released before its first repeat ----
      pulse_cnt = 0;
      for (int e = 1; e <= 22; e++) begin
         btn_in[3] = (e <= 8) ? bounce_pat[e-1] : (e <= 15);
         @(negedge clk);
         if (press[3]) pulse_cnt++;
         if (e == 14) exp_lvl[3] = 1'b1;
         if (e == 21) exp_lvl[3] = 1'b0;
         ep = (e == 14) ? 6'b001000 : 6'b000000;
         er = (e == 21) ? 6'b001000 : 6'b000000;
         check_out($sformatf("bounce e%0d", e), ep, er);
      end
      check("bounce.pulse_count", 32'(pulse_cnt), 32'd1);
      idle(4);

      // ---- hold-to-repeat on channel 0 alongside masked-off channel 1 ----
      for (int e = 1; e <= 40; e++) begin
         btn_in[1:0] = (e <= 30) ? 2'b11 : 2'b00;
         @(negedge clk);
         if (e == 6)  exp_lvl[1:0] = 2'b11;
         if (e == 36) exp_lvl[1:0] = 2'b00;
         ep = '0;
         ep[1] = (e == 6);
         ep[0] = (e == 6) || (e >= 16 && e <= 34 && (e - 16) % 3 == 0);
         er = (e == 36) ? 6'b000011 : 6'b000000;
         check_out($sformatf("repeat e%0d", e), ep, er);
      end
      idle(4);

      // ---- simultaneous press on channels 2 and 4 ----
      for (int e = 1; e <= 14; e++) begin
         btn_in[2] = (e <= 7);
         btn_in[4] = (e <= 7);
         @(negedge clk);
         if (e == 6)  exp_lvl = 6'b010100;
         if (e == 13) exp_lvl = 6'b000000;
         ep = (e == 6)  ? 6'b010100 : 6'b000000;
         er = (e == 13) ? 6'b010100 : 6'b000000;
         check_out($sformatf("simultaneous e%0d", e), ep, er);
      end
      idle(4);

      // ---- reset asserted at hold count 5 on channel 0 ----
      btn_in[0] = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         @(negedge clk);
         if (e == 6) exp_lvl[0] = 1'b1;
         ep = (e == 6) ? 6'b000001 : 6'b000000;
         check_out($sformatf("pre_reset e%0d", e), ep, '0);
      end
      #1 rst_n = 1'b0;
      #1;
      exp_lvl = '0;
      check_out("mid_reset_immediate", '0, '0);
      idle(2);
      check_out("mid_reset_held", '0, '0);
      rst_n = 1'b1;
      for (int e = 1; e <= 26; e++) begin
         btn_in[0] = (e <= 19);
         @(negedge clk);
         if (e == 6)  exp_lvl[0] = 1'b1;
         if (e == 25) exp_lvl[0] = 1'b0;
         ep = '0;
         ep[0] = (e == 6) || (e >= 16 && e < 25 && (e - 16) % 3 == 0);
         er = (e == 25) ? 6'b000001 : 6'b000000;
         check_out($sformatf("post_reset e%0d", e), ep, er);
      end
      idle(4);

      // ---- channel 5 held through reset ----
      btn_in[5] = 1'b1;
      rst_n = 1'b0;
      idle(3);
      check_out("held_in_reset", '0, '0);
      rst_n = 1'b1;
      pulse_cnt = 0;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         if (press[5]) pulse_cnt++;
         if (e == 6) exp_lvl[5] = 1'b1;
         ep = (e == 6) ? 6'b100000 : 6'b000000;
         check_out($sformatf("held_reset e%0d", e), ep, '0);
      end
      check("held_reset.pulse_count", 32'(pulse_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
